// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared encodings and helpers for the RAM access unit
package ram_pkg;

    // Access size encodings as driven by the control unit
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_t;

    // Access FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Direction constants shared with the control unit
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Byte lanes touched by an access; lane 3 is the byte at the base address
    // because the array read port is big-endian ({M[A],M[A+1],M[A+2],M[A+3]}).
    function automatic logic [3:0] lane_mask(size_t sz);
        case (sz)
            SZ_BYTE: return 4'b1000;
            SZ_HALF: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    // Natural-alignment test; the reserved size behaves as a word
    function automatic logic is_misaligned(size_t sz, logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_unit_if.sv
// rtl/ram_access_unit_if.sv - request/response bus between control unit and RAM stage (alignErr only with RAM_ALIGN_CHECK_EN)
interface ram_access_unit_if #(
    parameter int ADDR_W = 9
);
    logic              mfa;
    logic              rw;
    logic [1:0]        dataSize;
    logic [ADDR_W-1:0] address;
    logic [31:0]       dataIn;
    logic [31:0]       dataOut;
    logic              mfc;
`ifdef RAM_ALIGN_CHECK_EN
    logic              alignErr;

    modport master (
        output mfa, rw, dataSize, address, dataIn,
        input  dataOut, mfc, alignErr
    );

    modport slave (
        input  mfa, rw, dataSize, address, dataIn,
        output dataOut, mfc, alignErr
    );
`else
    modport master (
        output mfa, rw, dataSize, address, dataIn,
        input  dataOut, mfc
    );

    modport slave (
        input  mfa, rw, dataSize, address, dataIn,
        output dataOut, mfc
    );
`endif
endinterface

// File: rtl/ram_byte_array.sv
// rtl/ram_byte_array.sv - byte-wide storage with four big-endian byte lanes, addresses wrap modulo depth
module ram_byte_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    // Lane addresses; natural ADDR_W-bit overflow gives the wrap at the top of memory
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    assign a0 = addr;
    assign a1 = addr + ADDR_W'(1);
    assign a2 = addr + ADDR_W'(2);
    assign a3 = addr + ADDR_W'(3);

    // Per-lane byte writes; contents are never cleared
    always_ff @(posedge clk) begin
        if (we[3]) mem[a0] <= wdata[31:24];
        if (we[2]) mem[a1] <= wdata[23:16];
        if (we[1]) mem[a2] <= wdata[15:8];
        if (we[0]) mem[a3] <= wdata[7:0];
    end

    assign rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
endmodule

// File: rtl/ram_access_unit.sv
// rtl/ram_access_unit.sv - memory stage FSM with wait states, lane steering, optional RAM_ALIGN_CHECK_EN alignment check
module ram_access_unit
    import ram_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             reset,
    ram_access_unit_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    size_t             size_q;
    logic [31:0]       data_q;
    logic [31:0]       data_out_q;
    logic              mfc_q;

    logic [31:0]       rdata;
    logic [31:0]       read_data;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_we;
    logic              misaligned;

`ifdef RAM_ALIGN_CHECK_EN
    logic              align_q;
    assign misaligned   = is_misaligned(size_q, addr_q[1:0]);
    assign bus.alignErr = align_q;
`else
    assign misaligned = 1'b0;
`endif

    ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (Clk),
        .addr  (addr_q),
        .we    (lane_we),
        .wdata (lane_wdata),
        .rdata (rdata)
    );

    // Steer right-justified write data onto the leading lanes and pick read bytes back, zero-filled
    always_comb begin
        lane_wdata = 32'd0;
        read_data  = 32'd0;
        case (size_q)
            SZ_BYTE: begin
                lane_wdata = {data_q[7:0], 24'd0};
                read_data  = {24'd0, rdata[31:24]};
            end
            SZ_HALF: begin
                lane_wdata = {data_q[15:0], 16'd0};
                read_data  = {16'd0, rdata[31:16]};
            end
            default: begin
                lane_wdata = data_q;
                read_data  = rdata;
            end
        endcase
    end

    // Commit only from ACCESS; a reset landing on that same edge suppresses the write
    assign lane_we = (state == S_ACCESS && rw_q == RW_WRITE && !misaligned && !reset)
                   ? lane_mask(size_q) : 4'b0000;

    // Access sequencer: latch request, count wait states, access once, hold completion until mfa drops
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            mfc_q      <= 1'b0;
            data_out_q <= 32'd0;
`ifdef RAM_ALIGN_CHECK_EN
            align_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mfa) begin
                        addr_q   <= bus.address;
                        rw_q     <= bus.rw;
                        size_q   <= size_t'(bus.dataSize);
                        data_q   <= bus.dataIn;
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.mfa) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (rw_q == RW_READ && !misaligned) begin
                        data_out_q <= read_data;
                    end
`ifdef RAM_ALIGN_CHECK_EN
                    align_q <= misaligned;
`endif
                    mfc_q <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.mfa) begin
                        mfc_q <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
                        align_q <= 1'b0;
`endif
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dataOut = data_out_q;
    assign bus.mfc     = mfc_q;
endmodule
